apb_regfile_slave: RTL and testbench

APB3 completer that terminates transfers from the team's apb_master on the other end of the shared int1-style bus. It decodes PADDR into a small word-addressed register file and inserts a configurable number of wait states via PREADY. It flags illegal accesses with PSLVERR. It replaces the trivial always-ready slave with a protocol-accurate responder for bus and integration testing.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_reg_bank.sv | 52 +++++
 rtl/apb_regfile_slave.sv | 148 ++++++++++++++
 tb/tb_apb_regfile_slave.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB types and constants for the register-file completer.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  localparam logic APB_RESP_OKAY = 1'b0;
  localparam logic APB_RESP_ERR  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY
  } apb_state_t;

endpackage

// File: rtl/apb_reg_bank.sv
// Word register array with a constant ID register at index 0.
// Optional byte-lane write strobes when APB_PSTRB_EN is defined.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int                    NUM_REGS = 16,
  parameter int                    IDX_W    = 4,
  parameter logic [APB_DATA_W-1:0] ID_VALUE = 32'hA9B0_0001
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [APB_DATA_W-1:0] i_wdata,
`ifdef APB_PSTRB_EN
  input  logic [3:0]            i_strb,
`endif
  output logic [APB_DATA_W-1:0] o_rdata
);

  logic [APB_DATA_W-1:0] r_regs [1:NUM_REGS-1];
  logic [APB_DATA_W-1:0] w_wmask;

`ifdef APB_PSTRB_EN
  assign w_wmask = {{8{i_strb[3]}}, {8{i_strb[2]}}, {8{i_strb[1]}}, {8{i_strb[0]}}};
`else
  assign w_wmask = '1;
`endif

  // Index 0 has no storage, so the ID register cannot be written.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i_idx == IDX_W'(i)) r_regs[i] <= (r_regs[i] & ~w_wmask) | (i_wdata & w_wmask);
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    if (i_idx == '0) begin
      o_rdata = ID_VALUE;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i_idx == IDX_W'(i)) o_rdata = r_regs[i];
      end
    end
  end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB3 completer: decodes PADDR into apb_reg_bank, adds WAIT_STATES wait cycles, flags PSLVERR.
// Define APB_PSTRB_EN to add the PSTRB byte-lane write strobe input.
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 1,
  parameter logic [APB_DATA_W-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_ADDR_W-1:0] PADDR,
  input  logic [APB_DATA_W-1:0] PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [3:0]            PSTRB,
`endif
  output logic [APB_DATA_W-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  apb_state_t r_state, w_next;

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx, w_idx_sel, w_live_idx;
  logic                  r_write, r_err;
  logic [APB_DATA_W-1:0] r_wdata, w_rdata;
  logic                  w_setup, w_dec_err;
  logic                  w_write_sel, w_err_sel;
  logic                  w_capture, w_load_resp, w_complete, w_abort, w_bank_we;
`ifdef APB_PSTRB_EN
  logic [3:0]            r_strb;
`endif

  assign w_setup    = PSEL & ~PENABLE;
  assign w_live_idx = PADDR[IDX_W+1:2];
  assign w_dec_err  = (|PADDR[1:0]) | (PADDR[31:2] >= 30'(NUM_REGS)) |
                      (PWRITE & (PADDR[31:2] == '0));

  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_setup) w_next = (WAIT_STATES == 0) ? READY : WAIT;
      WAIT:    if (!PSEL) w_next = IDLE;
               else if (r_cnt == '0) w_next = READY;
      READY:   if (!PSEL || PENABLE) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // With zero wait states the response loads at the setup edge, so it must see the live decode.
  always_comb begin
    w_capture   = 1'b0;
    w_load_resp = 1'b0;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    w_idx_sel   = r_idx;
    w_write_sel = r_write;
    w_err_sel   = r_err;
    case (r_state)
      IDLE: begin
        w_capture   = w_setup;
        w_load_resp = w_setup && (WAIT_STATES == 0);
        w_idx_sel   = w_live_idx;
        w_write_sel = PWRITE;
        w_err_sel   = w_dec_err;
      end
      WAIT: begin
        w_abort     = ~PSEL;
        w_load_resp = PSEL && (r_cnt == '0);
      end
      READY: begin
        w_abort    = ~PSEL;
        w_complete = PSEL & PENABLE;
      end
      default: ;
    endcase
  end

  assign w_bank_we = w_complete & r_write & ~r_err;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= '0;
`ifdef APB_PSTRB_EN
      r_strb  <= '0;
`endif
      PREADY  <= 1'b0;
      PSLVERR <= APB_RESP_OKAY;
      PRDATA  <= '0;
    end else begin
      if (w_capture) begin
        r_idx   <= w_live_idx;
        r_write <= PWRITE;
        r_err   <= w_dec_err;
        r_wdata <= PWDATA;
        r_cnt   <= CNT_LOAD;
`ifdef APB_PSTRB_EN
        r_strb  <= PSTRB;
`endif
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_load_resp) begin
        PREADY  <= 1'b1;
        PSLVERR <= w_err_sel ? APB_RESP_ERR : APB_RESP_OKAY;
        PRDATA  <= (w_write_sel || w_err_sel) ? '0 : w_rdata;
      end else if (w_complete || w_abort) begin
        PREADY  <= 1'b0;
        PSLVERR <= APB_RESP_OKAY;
      end
    end
  end

  apb_reg_bank #(
    .NUM_REGS(NUM_REGS),
    .IDX_W   (IDX_W),
    .ID_VALUE(ID_VALUE)
  ) u_bank (
    .i_clk  (PCLK),
    .i_rst  (PRESET),
    .i_we   (w_bank_we),
    .i_idx  (w_idx_sel),
    .i_wdata(r_wdata),
`ifdef APB_PSTRB_EN
    .i_strb (r_strb),
`endif
    .o_rdata(w_rdata)
  );

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench for apb_regfile_slave: stimulus pushes expected responses, a monitor pops them.
module tb_apb_regfile_slave;
  import apb_pkg::*;

  localparam int WS = 1;

  logic        PCLK, PRESET, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
`ifdef APB_PSTRB_EN
  logic [3:0]  PSTRB;
`endif

  typedef struct {
    logic [31:0] rd;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   wcnt   = 0;

  apb_regfile_slave #(
    .NUM_REGS   (16),
    .WAIT_STATES(WS),
    .ID_VALUE   (32'hA9B0_0001)
  ) u_dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
`ifdef APB_PSTRB_EN
    .PSTRB  (PSTRB),
`endif
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge PCLK) begin
    if (PRESET || !(PSEL && PENABLE)) begin
      wcnt = 0;
    end else if (!PREADY) begin
      wcnt++;
    end else begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_completion: got a completion, expected none");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_prdata"}, PRDATA, e.rd);
        check({e.name, "_pslverr"}, {31'b0, PSLVERR}, {31'b0, e.err});
        check({e.name, "_waits"}, wcnt, WS);
      end
      wcnt = 0;
    end
  end

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, input string name);
    int n;
    exp_t e;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wdata;
    e.rd = exp_rd; e.err = exp_err; e.name = name;
    sb_q.push_back(e);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    forever begin
      @(negedge PCLK);
      if (PREADY) break;
      n++;
      if (n > 20) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s_timeout: PREADY stayed 0, expected 1 within 20 cycles", name);
        break;
      end
    end
    @(posedge PCLK); #1;
  endtask

  task automatic bus_idle();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
`ifdef APB_PSTRB_EN
    PSTRB = 4'hF;
`endif
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    check("rst_pready", {31'b0, PREADY}, 32'd0);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);

    for (int i = 1; i < 16; i++) apb_xfer(1'b0, 32'(i * 4), 32'd0, 32'd0, 1'b0, "rst_reg_read");
    bus_idle();

    apb_xfer(1'b1, 32'h8, 32'hABCD_1234, 32'd0, 1'b0, "wr_8");
    bus_idle();
    apb_xfer(1'b0, 32'h8, 32'd0, 32'hABCD_1234, 1'b0, "rd_8");
    bus_idle();

    apb_xfer(1'b0, 32'h0, 32'd0, 32'hA9B0_0001, 1'b0, "rd_id");
    apb_xfer(1'b1, 32'h0, 32'hFFFF_FFFF, 32'd0, 1'b1, "wr_id");
    apb_xfer(1'b0, 32'h0, 32'd0, 32'hA9B0_0001, 1'b0, "rd_id_again");
    bus_idle();

    apb_xfer(1'b0, 32'h40, 32'd0, 32'd0, 1'b1, "rd_oor");
    apb_xfer(1'b1, 32'h6, 32'hDEAD_BEEF, 32'd0, 1'b1, "wr_misaligned");
    apb_xfer(1'b0, 32'h2, 32'd0, 32'd0, 1'b1, "rd_misaligned");
    apb_xfer(1'b1, 32'h40, 32'hDEAD_BEEF, 32'd0, 1'b1, "wr_oor");
    apb_xfer(1'b0, 32'h4, 32'd0, 32'd0, 1'b0, "rd_4_untouched");
    apb_xfer(1'b1, 32'h3C, 32'hCAFE_F00D, 32'd0, 1'b0, "wr_last");
    apb_xfer(1'b0, 32'h3C, 32'd0, 32'hCAFE_F00D, 1'b0, "rd_last");
    apb_xfer(1'b0, 32'h8, 32'd0, 32'hABCD_1234, 1'b0, "rd_8_untouched");

    // Reset arrives during the wait cycle of a write to 0xC.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'hC; PWDATA = 32'h5555_AAAA;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("rstwait_pready", {31'b0, PREADY}, 32'd0);
    check("rstwait_prdata", PRDATA, 32'd0);
    check("rstwait_state", 32'(u_dut.r_state), 32'(IDLE));
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    apb_xfer(1'b0, 32'hC, 32'd0, 32'd0, 1'b0, "rd_c_after_rst");
    apb_xfer(1'b0, 32'h8, 32'd0, 32'd0, 1'b0, "rd_8_after_rst");
    apb_xfer(1'b1, 32'hC, 32'h1111_2222, 32'd0, 1'b0, "wr_c");
    bus_idle();

    // PSEL drops while in WAIT: transfer must abort without writing.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'hC; PWDATA = 32'h5555_AAAA;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    check("abort_state", 32'(u_dut.r_state), 32'(IDLE));
    check("abort_pready", {31'b0, PREADY}, 32'd0);
    @(posedge PCLK); #1;
    check("abort_pready_stays", {31'b0, PREADY}, 32'd0);
    apb_xfer(1'b0, 32'hC, 32'd0, 32'h1111_2222, 1'b0, "rd_c_after_abort");
    bus_idle();

    apb_xfer(1'b1, 32'h4, 32'h1234_5678, 32'd0, 1'b0, "b2b_wr_4");
    apb_xfer(1'b0, 32'h4, 32'd0, 32'h1234_5678, 1'b0, "b2b_rd_4");
`ifdef APB_PSTRB_EN
    PSTRB = 4'b0011;
    apb_xfer(1'b1, 32'h4, 32'hFFFF_FFFF, 32'd0, 1'b0, "strb_wr_4");
    PSTRB = 4'b0000;
    apb_xfer(1'b1, 32'h4, 32'h0000_0000, 32'd0, 1'b0, "strb0_wr_4");
    PSTRB = 4'hF;
    apb_xfer(1'b0, 32'h4, 32'd0, 32'h1234_FFFF, 1'b0, "strb_rd_4");
`endif
    bus_idle();
    repeat (3) @(posedge PCLK);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
